// File: rtl/vmem_pkg.sv
// Shared types and lane conversion helpers for the vector data memory.
// Lane values are fixed-point; only an ELEM_WIDTH-bit slice above FRAC_BITS is stored.
package vmem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int MAX_W = 64;

  // Extract the stored element from a lane value; clamp to all ones if saturating and the value overflows.
  function automatic logic [MAX_W-1:0] pack_lane(input logic [MAX_W-1:0] v, input int elem_w,
                                                 input int frac_w, input bit sat);
    logic [MAX_W-1:0] emask;
    logic [MAX_W-1:0] e;
    logic [MAX_W-1:0] over;
    emask = (64'd1 << elem_w) - 64'd1;
    e     = (v >> frac_w) & emask;
    over  = v >> (frac_w + elem_w);
    if (sat && (over != 64'd0)) e = emask;
    return e;
  endfunction

  function automatic logic [MAX_W-1:0] unpack_lane(input logic [MAX_W-1:0] e, input int elem_w,
                                                   input int frac_w);
    logic [MAX_W-1:0] emask;
    emask = (64'd1 << elem_w) - 64'd1;
    return (e & emask) << frac_w;
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/vmem_lane_codec.sv
// Combinational store packing (with optional saturation) and load unpacking for one lane.
module vmem_lane_codec
  import vmem_pkg::*;
#(
  parameter int ELEM_WIDTH = 8,
  parameter int LANE_WIDTH = 19,
  parameter int FRAC_BITS  = 10,
  parameter int SATURATE   = 1
) (
  input  logic [LANE_WIDTH-1:0] lane_in,
  output logic [ELEM_WIDTH-1:0] elem_out,
  input  logic [ELEM_WIDTH-1:0] elem_in,
  output logic [LANE_WIDTH-1:0] lane_out
);

  assign elem_out = ELEM_WIDTH'(pack_lane(MAX_W'(lane_in), ELEM_WIDTH, FRAC_BITS, SATURATE != 0));
  assign lane_out = LANE_WIDTH'(unpack_lane(MAX_W'(elem_in), ELEM_WIDTH, FRAC_BITS));

endmodule

// File: rtl/vector_memory.sv
// Vector data memory: registered read with valid, per-lane write mask, write-first forwarding,
// and a one-word-per-cycle clear sweep. Handshake: a request is accepted when its enable is high at a posedge while idle.
module vector_memory
  import vmem_pkg::*;
#(
  parameter int DEPTH         = 4096,
  parameter int LANES         = 6,
  parameter int ELEM_WIDTH    = 8,
  parameter int LANE_WIDTH    = 19,
  parameter int FRAC_BITS     = 10,
  parameter int ADDRESS_WIDTH = 32,
  parameter int SATURATE      = 1,
  parameter     INIT_FILE     = ""
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  output logic                          busy,
  input  logic                          readEnable,
  input  logic [ADDRESS_WIDTH-1:0]      readAddress,
  output logic                          readValid,
  output logic [LANES*LANE_WIDTH-1:0]   outputData,
  input  logic                          writeEnable,
  input  logic [ADDRESS_WIDTH-1:0]      writeAddress,
  input  logic [LANES-1:0]              writeMask,
  input  logic [LANES*LANE_WIDTH-1:0]   inputData,
  output logic                          fsm_state
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int WORD_W = LANES * ELEM_WIDTH;

  if ((FRAC_BITS + ELEM_WIDTH > LANE_WIDTH) || (LANES < 1) || (DEPTH < 2)) begin : g_bad_params
    $error("vector_memory: illegal parameter combination");
  end

  logic [WORD_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == CLEAR);
  assign fsm_state = state_q;

  logic                      idle;
  logic                      rd_in_range, wr_in_range;
  logic [IDX_W-1:0]          rd_idx, wr_idx;
  logic                      rd_ok, wr_ok, same_addr;
  logic [WORD_W-1:0]         rd_word;
  logic [ELEM_WIDTH-1:0]     pk [LANES];
  logic [LANES*LANE_WIDTH-1:0] rd_bus;

  assign idle        = (state_q == IDLE);
  assign rd_in_range = (readAddress < ADDRESS_WIDTH'(DEPTH));
  assign wr_in_range = (writeAddress < ADDRESS_WIDTH'(DEPTH));
  assign rd_idx      = readAddress[IDX_W-1:0];
  assign wr_idx      = writeAddress[IDX_W-1:0];
  assign rd_ok       = idle && readEnable;
  assign wr_ok       = idle && writeEnable && wr_in_range && (|writeMask);
  assign same_addr   = wr_ok && (wr_idx == rd_idx);
  assign rd_word     = mem[rd_idx];

  // Forwarded element: freshly packed data for masked lanes of a same-address write, stored data otherwise.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [ELEM_WIDTH-1:0] fwd_elem;

    assign fwd_elem = (same_addr && writeMask[i]) ? pk[i]
                    : rd_word[lane_lsb(i, ELEM_WIDTH) +: ELEM_WIDTH];

    vmem_lane_codec #(
      .ELEM_WIDTH (ELEM_WIDTH),
      .LANE_WIDTH (LANE_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .SATURATE   (SATURATE)
    ) u_codec (
      .lane_in  (inputData[lane_lsb(i, LANE_WIDTH) +: LANE_WIDTH]),
      .elem_out (pk[i]),
      .elem_in  (fwd_elem),
      .lane_out (rd_bus[lane_lsb(i, LANE_WIDTH) +: LANE_WIDTH])
    );
  end

  // Storage is never reset; an asserted reset forces IDLE so the sweep stops writing immediately.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (writeMask[i]) mem[wr_idx][i*ELEM_WIDTH +: ELEM_WIDTH] <= pk[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readValid  <= 1'b0;
      outputData <= '0;
    end else begin
      readValid <= rd_ok;
      if (rd_ok) outputData <= rd_in_range ? rd_bus : '0;
    end
  end

endmodule

// File: tb/tb_vector_memory.sv
// Bench for vector_memory with DEPTH=16: table-driven read/write vectors plus clear and reset-abort sequences.
module tb_vector_memory;

  localparam int DEPTH = 16;
  localparam int BW    = 6 * 19;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          readEnable = 1'b0;
  logic [31:0]   readAddress = '0;
  logic          writeEnable = 1'b0;
  logic [31:0]   writeAddress = '0;
  logic [5:0]    writeMask = '0;
  logic [BW-1:0] inputData = '0;

  logic          busy, readValid, fsm_state;
  logic [BW-1:0] outputData;
  logic          busy_t, readValid_t, fsm_state_t;
  logic [BW-1:0] outputData_t;

  vector_memory #(.DEPTH(DEPTH), .SATURATE(1)) u_dut (
    .clk(clk), .reset(reset), .clear(clear), .busy(busy),
    .readEnable(readEnable), .readAddress(readAddress), .readValid(readValid), .outputData(outputData),
    .writeEnable(writeEnable), .writeAddress(writeAddress), .writeMask(writeMask), .inputData(inputData),
    .fsm_state(fsm_state)
  );

  vector_memory #(.DEPTH(DEPTH), .SATURATE(0)) u_dut_trunc (
    .clk(clk), .reset(reset), .clear(clear), .busy(busy_t),
    .readEnable(readEnable), .readAddress(readAddress), .readValid(readValid_t), .outputData(outputData_t),
    .writeEnable(writeEnable), .writeAddress(writeAddress), .writeMask(writeMask), .inputData(inputData),
    .fsm_state(fsm_state_t)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          clr;
    logic          re;
    logic [31:0]   ra;
    logic          we;
    logic [31:0]   wa;
    logic [5:0]    wm;
    logic [BW-1:0] wd;
    logic          exp_valid;
    logic [BW-1:0] exp;
    logic [BW-1:0] exp_t;
  } vec_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic          exp_v_q[$];
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] exp_t_q[$];
  logic [BW-1:0] last_exp = '0;
  logic [BW-1:0] last_exp_t = '0;
  vec_t          tbl[16];

  function automatic logic [BW-1:0] bus19(input logic [18:0] l0, l1, l2, l3, l4, l5);
    return {l5, l4, l3, l2, l1, l0};
  endfunction

  function automatic logic [18:0] ln(input logic [7:0] e);
    return {1'b0, e, 10'b0};
  endfunction

  function automatic logic [BW-1:0] lanes6(input logic [7:0] e0, e1, e2, e3, e4, e5);
    return bus19(ln(e0), ln(e1), ln(e2), ln(e3), ln(e4), ln(e5));
  endfunction

  function automatic logic [BW-1:0] fill(input logic [7:0] e);
    return lanes6(e, e, e, e, e, e);
  endfunction

  function automatic vec_t mkv(input logic clr, re, input logic [31:0] ra, input logic we,
                               input logic [31:0] wa, input logic [5:0] wm, input logic [BW-1:0] wd,
                               input logic ev, input logic [BW-1:0] exp, input logic [BW-1:0] exp_t);
    vec_t v;
    v.clr = clr; v.re = re; v.ra = ra; v.we = we; v.wa = wa; v.wm = wm; v.wd = wd;
    v.exp_valid = ev; v.exp = exp; v.exp_t = exp_t;
    return v;
  endfunction

  function automatic vec_t rd(input logic [31:0] a, input logic [BW-1:0] e);
    return mkv(1'b0, 1'b1, a, 1'b0, 32'd0, 6'h00, '0, 1'b1, e, e);
  endfunction

  function automatic vec_t wr(input logic [31:0] a, input logic [5:0] m, input logic [BW-1:0] d);
    return mkv(1'b0, 1'b0, 32'd0, 1'b1, a, m, d, 1'b0, '0, '0);
  endfunction

  function automatic vec_t idle_v();
    return mkv(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 6'h00, '0, 1'b0, '0, '0);
  endfunction

  task automatic cmp(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    logic ev;
    clear        = v.clr;
    readEnable   = v.re;
    readAddress  = v.ra;
    writeEnable  = v.we;
    writeAddress = v.wa;
    writeMask    = v.wm;
    inputData    = v.wd;
    exp_v_q.push_back(v.exp_valid);
    if (v.exp_valid) begin
      exp_q.push_back(v.exp);
      exp_t_q.push_back(v.exp_t);
    end
    tick();
    clear       = 1'b0;
    readEnable  = 1'b0;
    writeEnable = 1'b0;
    ev = exp_v_q.pop_front();
    cmp("read_valid", BW'(readValid), BW'(ev));
    if (ev) begin
      last_exp   = exp_q.pop_front();
      last_exp_t = exp_t_q.pop_front();
      cmp("read_data", outputData, last_exp);
      cmp("read_data_trunc", outputData_t, last_exp_t);
    end else begin
      cmp("data_hold", outputData, last_exp);
    end
  endtask

  task automatic sweep_check();
    int c;
    apply(mkv(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 6'h00, '0, 1'b0, '0, '0));
    cmp("busy_after_clear", BW'(busy), BW'(1'b1));
    c = 0;
    while (busy && c < 100) begin
      if (c < DEPTH - 1)
        apply(mkv(1'b1, 1'b1, 32'd5, 1'b1, 32'd3, 6'h3F, fill(8'hFF), 1'b0, '0, '0));
      else
        apply(idle_v());
      c++;
    end
    cmp("busy_cycles", BW'(c), BW'(DEPTH));
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_busy", BW'(busy), '0);
    cmp("reset_valid", BW'(readValid), '0);
    cmp("reset_data", outputData, '0);
    reset = 1'b0;
    tick();

    // clear sweep: busy for DEPTH cycles, requests ignored, then everything reads zero
    sweep_check();
    for (int a = 0; a < DEPTH; a++) apply(rd(a, '0));

    tbl[0]  = wr(32'd5, 6'h3F, lanes6(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6));
    tbl[1]  = rd(32'd5, lanes6(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6));
    tbl[2]  = wr(32'd7, 6'h3F, fill(8'hAA));
    tbl[3]  = mkv(1'b0, 1'b1, 32'd7, 1'b1, 32'd7, 6'b000101, fill(8'h55), 1'b1,
                  lanes6(8'h55, 8'hAA, 8'h55, 8'hAA, 8'hAA, 8'hAA),
                  lanes6(8'h55, 8'hAA, 8'h55, 8'hAA, 8'hAA, 8'hAA));
    tbl[4]  = wr(32'd2, 6'h3F, bus19(19'h40000, 19'h003FF, 19'h7FFFF, 19'h3FFFF, 19'h12345, 19'h5ABCD));
    tbl[5]  = mkv(1'b0, 1'b1, 32'd2, 1'b0, 32'd0, 6'h00, '0, 1'b1,
                  lanes6(8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h48, 8'hFF),
                  lanes6(8'h00, 8'h00, 8'hFF, 8'hFF, 8'h48, 8'h6A));
    tbl[6]  = mkv(1'b0, 1'b1, 32'd16, 1'b1, 32'd16, 6'h3F, fill(8'h77), 1'b1, '0, '0);
    tbl[7]  = rd(32'd0, '0);
    tbl[8]  = mkv(1'b0, 1'b1, 32'd5, 1'b1, 32'd5, 6'h00, fill(8'hEE), 1'b1,
                  lanes6(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6), lanes6(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6));
    tbl[9]  = mkv(1'b0, 1'b1, 32'd9, 1'b1, 32'd9, 6'h3F, fill(8'h99), 1'b1, fill(8'h99), fill(8'h99));
    tbl[10] = rd(32'd7, lanes6(8'h55, 8'hAA, 8'h55, 8'hAA, 8'hAA, 8'hAA));
    tbl[11] = rd(32'd9, fill(8'h99));
    tbl[12] = wr(32'd15, 6'b100000, fill(8'h33));
    tbl[13] = rd(32'd15, lanes6(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33));
    tbl[14] = rd(32'd3, '0);
    tbl[15] = rd(32'hFFFF_FFFF, '0);
    for (int i = 0; i < 16; i++) apply(tbl[i]);

    // out-of-range write left every word untouched
    apply(rd(32'd0, '0));
    apply(rd(32'd15, lanes6(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33)));

    // reset during a sweep: words 0..3 cleared, 5..15 keep their data
    for (int a = 0; a < DEPTH; a++) apply(wr(a, 6'h3F, fill(8'hFF)));
    apply(rd(32'd0, fill(8'hFF)));
    apply(mkv(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 6'h00, '0, 1'b0, '0, '0));
    cmp("busy_mid_clear", BW'(busy), BW'(1'b1));
    repeat (4) apply(idle_v());
    reset = 1'b1;
    #2;
    cmp("abort_busy", BW'(busy), '0);
    cmp("abort_valid", BW'(readValid), '0);
    cmp("abort_data", outputData, '0);
    last_exp   = '0;
    last_exp_t = '0;
    tick();
    reset = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      if (a < 4) apply(rd(a, '0));
      else if (a > 4) apply(rd(a, fill(8'hFF)));
    end
    apply(idle_v());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
